// File: rtl/markov_train_sequencer_pkg.sv
// Shared constants for the Markov training sequencer: default widths, FSM
// state encodings and error codes reported on err.
package markov_train_sequencer_pkg;

   localparam int DEF_NOTE_BIT_LEN   = 8;
   localparam int DEF_DELAY_BIT_LEN  = 8;
   localparam int DEF_SONG_INPUT_LEN = 4;
   localparam int DEF_WORD_BITS      = DEF_NOTE_BIT_LEN + DEF_DELAY_BIT_LEN;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FILL   = 3'd1;
   localparam logic [2:0] ST_LAUNCH = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_FINISH = 3'd4;

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_SHORT   = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_ABORT   = 2'd3;

endpackage

// File: rtl/markov_window_shift.sv
// Sliding fragment window: newest word enters the LS slot, oldest word sits in
// the MS slot. Clear has priority over shift.
module markov_window_shift
   import markov_train_sequencer_pkg::*;
#(
   parameter int WORD_BITS = DEF_WORD_BITS,
   parameter int DEPTH     = DEF_SONG_INPUT_LEN
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       shift_en,
   input  logic [WORD_BITS-1:0]       shift_in,
   output logic [DEPTH*WORD_BITS-1:0] fragment
);

   localparam int FRAG_BITS = DEPTH * WORD_BITS;

   always_ff @(posedge clk) begin
      if (!reset) begin
         fragment <= '0;
      end else if (clear) begin
         fragment <= '0;
      end else if (shift_en) begin
         fragment <= {fragment[FRAG_BITS-WORD_BITS-1:0], shift_in};
      end
   end

endmodule

// File: rtl/markov_train_sequencer.sv
// Training controller: streams a song from memory into a sliding window and
// launches the Markov learner once per window position.
module markov_train_sequencer
   import markov_train_sequencer_pkg::*;
#(
   parameter int NOTE_BIT_LEN   = DEF_NOTE_BIT_LEN,
   parameter int DELAY_BIT_LEN  = DEF_DELAY_BIT_LEN,
   parameter int SONG_INPUT_LEN = DEF_SONG_INPUT_LEN,
   parameter int ADDR_BITS      = 8,
   parameter int DONE_TIMEOUT   = 1024
) (
   input  logic                                                  clk,
   input  logic                                                  reset,
   input  logic                                                  start,
   input  logic                                                  abort,
   input  logic [ADDR_BITS:0]                                    song_len,
   output logic                                                  mem_rd_en,
   output logic [ADDR_BITS-1:0]                                  mem_addr,
   input  logic [NOTE_BIT_LEN+DELAY_BIT_LEN-1:0]                 mem_rd_data,
   output logic                                                  learn_start,
   output logic [SONG_INPUT_LEN*(NOTE_BIT_LEN+DELAY_BIT_LEN)-1:0] learn_fragment,
   input  logic                                                  learn_done,
   output logic                                                  busy,
   output logic                                                  done,
   output logic [1:0]                                            err,
   output logic [ADDR_BITS:0]                                    frag_count
);

   localparam int WORD_BITS = NOTE_BIT_LEN + DELAY_BIT_LEN;
   localparam int NEED_BITS = $clog2(SONG_INPUT_LEN + 1);
   localparam int TMO_BITS  = $clog2(DONE_TIMEOUT + 1);

   localparam logic [ADDR_BITS:0] PTR_ONE   = (ADDR_BITS+1)'(1);
   localparam logic [ADDR_BITS:0] MIN_LEN   = (ADDR_BITS+1)'(SONG_INPUT_LEN);
   localparam logic [NEED_BITS-1:0] NEED_ONE  = NEED_BITS'(1);
   localparam logic [NEED_BITS-1:0] NEED_FULL = NEED_BITS'(SONG_INPUT_LEN);
   localparam logic [TMO_BITS-1:0] TMO_ONE  = TMO_BITS'(1);
   localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'(DONE_TIMEOUT - 1);

   logic [2:0]           state;
   logic [ADDR_BITS:0]   rd_ptr;
   logic [ADDR_BITS:0]   len_q;
   logic [NEED_BITS-1:0] rd_left;
   logic [NEED_BITS-1:0] cap_left;
   logic [TMO_BITS-1:0]  tmo_cnt;
   logic                 rd_pend;
   logic                 done_q;
   logic                 done_rise;
   logic                 frag_clear;
   logic                 frag_shift;

   // Abort gates strobes combinationally so nothing new is issued in its cycle.
   assign mem_rd_en   = (state == ST_FILL) && (rd_left != '0) && !abort;
   assign mem_addr    = rd_ptr[ADDR_BITS-1:0];
   assign learn_start = (state == ST_LAUNCH) && !abort;
   assign busy        = (state != ST_IDLE);
   assign done        = (state == ST_FINISH);
   assign done_rise   = learn_done && !done_q;
   assign frag_clear  = (state == ST_IDLE) && start;
   assign frag_shift  = (state == ST_FILL) && rd_pend && !abort;

   markov_window_shift #(
      .WORD_BITS (WORD_BITS),
      .DEPTH     (SONG_INPUT_LEN)
   ) u_window (
      .clk      (clk),
      .reset    (reset),
      .clear    (frag_clear),
      .shift_en (frag_shift),
      .shift_in (mem_rd_data),
      .fragment (learn_fragment)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ST_IDLE;
         rd_ptr     <= '0;
         len_q      <= '0;
         rd_left    <= '0;
         cap_left   <= '0;
         tmo_cnt    <= '0;
         rd_pend    <= 1'b0;
         done_q     <= 1'b0;
         err        <= ERR_OK;
         frag_count <= '0;
      end else begin
         // done_q tracks learn_done continuously so a held level yields one edge.
         done_q  <= learn_done;
         rd_pend <= mem_rd_en;
         if (mem_rd_en) begin
            rd_ptr  <= rd_ptr + PTR_ONE;
            rd_left <= rd_left - NEED_ONE;
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  len_q      <= song_len;
                  frag_count <= '0;
                  rd_ptr     <= '0;
                  tmo_cnt    <= '0;
                  if (song_len < MIN_LEN) begin
                     err   <= ERR_SHORT;
                     state <= ST_FINISH;
                  end else begin
                     err      <= ERR_OK;
                     rd_left  <= NEED_FULL;
                     cap_left <= NEED_FULL;
                     state    <= ST_FILL;
                  end
               end
            end
            ST_FILL: begin
               if (abort) begin
                  err   <= ERR_ABORT;
                  state <= ST_FINISH;
               end else if (rd_pend) begin
                  cap_left <= cap_left - NEED_ONE;
                  if (cap_left == NEED_ONE) state <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               if (abort) begin
                  err   <= ERR_ABORT;
                  state <= ST_FINISH;
               end else begin
                  frag_count <= frag_count + PTR_ONE;
                  tmo_cnt    <= '0;
                  state      <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (abort) begin
                  err   <= ERR_ABORT;
                  state <= ST_FINISH;
               end else if (done_rise) begin
                  if (rd_ptr == len_q) begin
                     state <= ST_FINISH;
                  end else begin
                     rd_left  <= NEED_ONE;
                     cap_left <= NEED_ONE;
                     state    <= ST_FILL;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  err   <= ERR_TIMEOUT;
                  state <= ST_FINISH;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_ONE;
               end
            end
            ST_FINISH: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_markov_train_sequencer.sv
// Scoreboard bench for markov_train_sequencer: stimulus queues expected reads,
// fragments and completions; a negedge monitor pops and compares them.
module tb_markov_train_sequencer;

   localparam int AB = 8;
   localparam int WB = 16;
   localparam int FB = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AB:0]   song_len = '0;
   logic          mem_rd_en;
   logic [AB-1:0] mem_addr;
   logic [WB-1:0] mem_rd_data = '0;
   logic          learn_start;
   logic [FB-1:0] learn_fragment;
   logic          learn_done = 1'b0;
   logic          busy;
   logic          done;
   logic [1:0]    err;
   logic [AB:0]   frag_count;

   int vectors = 0;
   int miscompares = 0;
   int learner_mode = 0;

   logic [AB-1:0] exp_addr_q[$];
   logic [FB-1:0] exp_frag_q[$];
   logic [1:0]    exp_err_q[$];
   int            exp_cnt_q[$];

   always #5 clk = ~clk;

   markov_train_sequencer #(
      .NOTE_BIT_LEN   (8),
      .DELAY_BIT_LEN  (8),
      .SONG_INPUT_LEN (4),
      .ADDR_BITS      (AB),
      .DONE_TIMEOUT   (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .abort          (abort),
      .song_len       (song_len),
      .mem_rd_en      (mem_rd_en),
      .mem_addr       (mem_addr),
      .mem_rd_data    (mem_rd_data),
      .learn_start    (learn_start),
      .learn_fragment (learn_fragment),
      .learn_done     (learn_done),
      .busy           (busy),
      .done           (done),
      .err            (err),
      .frag_count     (frag_count)
   );

   // Song memory: word at address a is 0x0101 + a, one-cycle read latency.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= 16'h0101 + {8'h00, mem_addr};
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: actual event seen, required none", name);
   endtask

   // Learner model: mode 0 pulses done 3 cycles after start, 1 never answers,
   // 2 raises done after 3 cycles and holds it, 3 pulses done after 10 cycles.
   initial forever begin
      @(negedge clk);
      if (learn_start === 1'b1) begin
         case (learner_mode)
            0: begin repeat (3) @(posedge clk); #1 learn_done = 1'b1; @(posedge clk); #1 learn_done = 1'b0; end
            2: begin repeat (3) @(posedge clk); #1 learn_done = 1'b1; end
            3: begin repeat (10) @(posedge clk); #1 learn_done = 1'b1; @(posedge clk); #1 learn_done = 1'b0; end
            default: ;
         endcase
      end
   end

   // Monitor
   initial begin
      wait (reset === 1'b1);
      forever begin
         @(negedge clk);
         if (mem_rd_en === 1'b1) begin
            if (exp_addr_q.size() == 0) unexpected("mem_read");
            else check("mem_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
         end
         if (learn_start === 1'b1) begin
            if (exp_frag_q.size() == 0) unexpected("learn_start");
            else check("fragment", learn_fragment, exp_frag_q.pop_front());
         end
         if (done === 1'b1) begin
            if (exp_err_q.size() == 0) unexpected("done");
            else begin
               check("err", 64'(err), 64'(exp_err_q.pop_front()));
               check("frag_count", 64'(frag_count), 64'(exp_cnt_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic push_reads(input int first, input int last);
      for (int a = first; a <= last; a++) exp_addr_q.push_back(AB'(a));
   endtask

   task automatic push_done(input logic [1:0] e, input int n);
      exp_err_q.push_back(e);
      exp_cnt_q.push_back(n);
   endtask

   task automatic start_run(input int len);
      @(posedge clk); #1;
      song_len = (AB+1)'(len);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int i;
      for (i = 0; i < budget && done !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      check(name, 64'(done), 64'd1);
   endtask

   task automatic gap();
      repeat (15) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_err"}, 64'(err), 64'd0);
      check({tag, "_frag_count"}, 64'(frag_count), 64'd0);
      check({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
      check({tag, "_learn_start"}, 64'(learn_start), 64'd0);
      check({tag, "_fragment"}, learn_fragment, 64'd0);
   endtask

   initial begin
      int k;
      int seen;

      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset");
      reset = 1'b1;
      gap();

      // Clean run, song_len 6; a start pulse while busy must be ignored.
      learner_mode = 0;
      push_reads(0, 5);
      exp_frag_q.push_back(64'h0101_0102_0103_0104);
      exp_frag_q.push_back(64'h0102_0103_0104_0105);
      exp_frag_q.push_back(64'h0103_0104_0105_0106);
      push_done(2'd0, 3);
      start_run(6);
      repeat (12) @(posedge clk);
      #1 start = 1'b1; song_len = 9'd3;
      @(posedge clk); #1 start = 1'b0;
      wait_done("done_len6", 200);
      @(posedge clk); #1;
      check("busy_after_done", 64'(busy), 64'd0);
      gap();

      // Too short: no reads, immediate completion with err 1.
      push_done(2'd1, 0);
      start_run(3);
      wait_done("done_short", 2);
      gap();

      // Exactly one window: learn_start five cycles after acceptance.
      push_reads(0, 3);
      exp_frag_q.push_back(64'h0101_0102_0103_0104);
      push_done(2'd0, 1);
      start_run(4);
      for (k = 1; k < 10; k++) begin
         @(posedge clk); #1;
         if (learn_start === 1'b1) break;
      end
      check("launch_latency", 64'(k), 64'd5);
      wait_done("done_len4", 50);
      gap();

      // Learner silent: timeout after 16 WAIT cycles, err held afterwards.
      learner_mode = 1;
      push_reads(0, 3);
      exp_frag_q.push_back(64'h0101_0102_0103_0104);
      push_done(2'd2, 1);
      start_run(4);
      for (k = 0; k < 20 && learn_start !== 1'b1; k++) begin
         @(posedge clk); #1;
      end
      for (k = 0; k < 40 && done !== 1'b1; k++) begin
         @(posedge clk); #1;
      end
      check("timeout_latency", 64'(k), 64'd17);
      repeat (3) @(posedge clk);
      #1 check("err_held", 64'(err), 64'd2);
      gap();

      // Abort in WAIT of the second fragment.
      learner_mode = 3;
      push_reads(0, 4);
      exp_frag_q.push_back(64'h0101_0102_0103_0104);
      exp_frag_q.push_back(64'h0102_0103_0104_0105);
      push_done(2'd3, 2);
      start_run(6);
      seen = 0;
      for (k = 0; k < 100 && seen < 2; k++) begin
         @(posedge clk); #1;
         if (learn_start === 1'b1) seen++;
      end
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1;
      check("abort_finish_next", 64'(done), 64'd1);
      abort = 1'b0;
      wait_done("done_abort", 2);
      gap();

      // learn_done held high: only its first rising edge counts.
      learner_mode = 2;
      push_reads(0, 4);
      exp_frag_q.push_back(64'h0101_0102_0103_0104);
      exp_frag_q.push_back(64'h0102_0103_0104_0105);
      push_done(2'd2, 2);
      start_run(6);
      wait_done("done_held", 100);
      learn_done = 1'b0;
      gap();

      // start and abort together: accepted, then aborted with no reads.
      learner_mode = 0;
      push_done(2'd3, 0);
      @(posedge clk); #1;
      song_len = 9'd6; start = 1'b1; abort = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 abort = 1'b0;
      wait_done("done_start_abort", 4);
      gap();

      // Reset during FILL, then a clean rerun from address 0.
      push_reads(0, 1);
      start_run(6);
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1 check_reset_outputs("midrun");
      @(posedge clk); #1 reset = 1'b1;
      gap();
      push_reads(0, 5);
      exp_frag_q.push_back(64'h0101_0102_0103_0104);
      exp_frag_q.push_back(64'h0102_0103_0104_0105);
      exp_frag_q.push_back(64'h0103_0104_0105_0106);
      push_done(2'd0, 3);
      start_run(6);
      wait_done("done_rerun", 200);
      gap();

      check("addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
      check("frag_q_empty", 64'(exp_frag_q.size()), 64'd0);
      check("done_q_empty", 64'(exp_err_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
